// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults for the programmed-I/O port endpoint.
//   DATA_W_DEF    - default port data width
//   OUT_DEPTH_DEF - default output FIFO depth (power of two, >= 2)
//   count_w()     - width of an occupancy counter able to hold 0..depth
package io_port_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned OUT_DEPTH_DEF = 4;

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned OUT_COUNT_W_DEF = count_w(OUT_DEPTH_DEF);

endpackage

// File: rtl/io_out_fifo.sv
// io_out_fifo: synchronous show-ahead FIFO buffering CPU OUT words.
// Ports:
//   clock, clear       - rising-edge clock, async active-high reset
//   push, data_in      - write request and word
//   pop                - read request (ignored while empty)
//   data_out           - head entry, valid whenever empty == 0
//   full, empty, count - occupancy status
//   drop               - push rejected this cycle (full, no simultaneous pop)
module io_out_fifo
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = OUT_DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic [count_w(DEPTH)-1:0]  count,
    output logic                       drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when a pop frees the head slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign data_out = mem[rd_ptr];

    // Storage and pointers; memory is reset so the head reads 0 after clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_device.sv
// io_port_device: device-side endpoint for the CPU's programmed I/O ports.
// Ports:
//   clock, clear                  - rising-edge clock, async active-high reset
//   outport_data, outport_wr      - word written by an OUT instruction
//   inport_data, inport_rd        - word sampled by an IN instruction
//   ext_in_data/valid/ready       - external producer handshake into holding reg
//   ext_out_data/valid/ready      - external consumer handshake out of the FIFO
//   out_count                     - output FIFO occupancy
//   inport_fresh                  - holding register has an unread word
//   out_overflow, in_underrun     - sticky error flags
//   clr_flags                     - synchronous clear of the sticky flags
module io_port_device
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [DATA_W-1:0]             outport_data,
    input  logic                          outport_wr,
    output logic [DATA_W-1:0]             inport_data,
    input  logic                          inport_rd,
    input  logic [DATA_W-1:0]             ext_in_data,
    input  logic                          ext_in_valid,
    output logic                          ext_in_ready,
    output logic [DATA_W-1:0]             ext_out_data,
    output logic                          ext_out_valid,
    input  logic                          ext_out_ready,
    output logic [count_w(OUT_DEPTH)-1:0] out_count,
    output logic                          inport_fresh,
    output logic                          out_overflow,
    output logic                          in_underrun,
    input  logic                          clr_flags
);

    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_drop;

    // Holding register may refill in the same cycle the CPU reads it.
    assign ext_in_ready = ~inport_fresh | inport_rd;
    assign accept       = ext_in_valid & ext_in_ready;

    assign ext_out_valid = ~fifo_empty;

    // Input holding register: a read without refill keeps the stale word.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            inport_data  <= '0;
            inport_fresh <= 1'b0;
        end else if (accept) begin
            inport_data  <= ext_in_data;
            inport_fresh <= 1'b1;
        end else if (inport_rd) begin
            inport_fresh <= 1'b0;
        end
    end

    // Sticky flags; a set condition wins over a simultaneous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            out_overflow <= 1'b0;
            in_underrun  <= 1'b0;
        end else begin
            if (fifo_drop) begin
                out_overflow <= 1'b1;
            end else if (clr_flags) begin
                out_overflow <= 1'b0;
            end
            if (inport_rd & ~inport_fresh) begin
                in_underrun <= 1'b1;
            end else if (clr_flags) begin
                in_underrun <= 1'b0;
            end
        end
    end

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clock    (clock),
        .clear    (clear),
        .push     (outport_wr),
        .data_in  (outport_data),
        .pop      (ext_out_ready),
        .data_out (ext_out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (out_count),
        .drop     (fifo_drop)
    );

endmodule

// File: tb/tb_io_port_device.sv
// tb_io_port_device: directed self-checking bench for io_port_device.
// Outputs are checked and inputs driven on the falling edge of clock.
module tb_io_port_device;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OUT_DEPTH = 4;
    localparam int unsigned CNT_W     = $clog2(OUT_DEPTH) + 1;

    logic              clock = 1'b0;
    logic              clear;
    logic [DATA_W-1:0] outport_data;
    logic              outport_wr;
    logic [DATA_W-1:0] inport_data;
    logic              inport_rd;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              inport_fresh;
    logic              out_overflow;
    logic              in_underrun;
    logic              clr_flags;

    int tests_run    = 0;
    int tests_failed = 0;

    io_port_device #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .outport_data  (outport_data),
        .outport_wr    (outport_wr),
        .inport_data   (inport_data),
        .inport_rd     (inport_rd),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .out_count     (out_count),
        .inport_fresh  (inport_fresh),
        .out_overflow  (out_overflow),
        .in_underrun   (in_underrun),
        .clr_flags     (clr_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inport_data"}, inport_data, 32'h0);
        check({tag, "_inport_fresh"}, 32'(inport_fresh), 32'h0);
        check({tag, "_out_count"}, 32'(out_count), 32'h0);
        check({tag, "_ext_out_valid"}, 32'(ext_out_valid), 32'h0);
        check({tag, "_ext_out_data"}, ext_out_data, 32'h0);
        check({tag, "_out_overflow"}, 32'(out_overflow), 32'h0);
        check({tag, "_in_underrun"}, 32'(in_underrun), 32'h0);
        check({tag, "_ext_in_ready"}, 32'(ext_in_ready), 32'h1);
    endtask

    initial begin
        clear         = 1'b1;
        outport_data  = '0;
        outport_wr    = 1'b0;
        inport_rd     = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        ext_out_ready = 1'b0;
        clr_flags     = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check_reset_values("reset");
        clear = 1'b0;

        // Streaming 0x11, 0x22, 0x33 with consumer always ready
        ext_out_ready = 1'b1;
        outport_wr    = 1'b1;
        outport_data  = 32'h11;
        @(negedge clock);
        check("stream_valid0", 32'(ext_out_valid), 32'h1);
        check("stream_head0", ext_out_data, 32'h11);
        outport_data = 32'h22;
        @(negedge clock);
        check("stream_head1", ext_out_data, 32'h22);
        check("stream_count1", 32'(out_count), 32'h1);
        outport_data = 32'h33;
        @(negedge clock);
        check("stream_head2", ext_out_data, 32'h33);
        outport_wr = 1'b0;
        @(negedge clock);
        check("stream_count_end", 32'(out_count), 32'h0);
        check("stream_valid_end", 32'(ext_out_valid), 32'h0);

        // Overflow: five writes into a 4-deep FIFO with consumer stalled
        ext_out_ready = 1'b0;
        outport_wr    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            outport_data = 32'hA0 + 32'(i);
            @(negedge clock);
        end
        outport_wr = 1'b0;
        check("ovf_count", 32'(out_count), 32'h4);
        check("ovf_flag", 32'(out_overflow), 32'h1);
        ext_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", ext_out_data, 32'hA0 + 32'(i));
            @(negedge clock);
        end
        check("ovf_drained_count", 32'(out_count), 32'h0);
        check("ovf_flag_sticky", 32'(out_overflow), 32'h1);
        ext_out_ready = 1'b0;
        clr_flags     = 1'b1;
        @(negedge clock);
        clr_flags = 1'b0;
        check("ovf_flag_cleared", 32'(out_overflow), 32'h0);

        // Full FIFO with simultaneous push and pop
        outport_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            outport_data = 32'(i);
            @(negedge clock);
        end
        check("fullpp_count_before", 32'(out_count), 32'h4);
        outport_data  = 32'hB0;
        ext_out_ready = 1'b1;
        @(negedge clock);
        outport_wr = 1'b0;
        check("fullpp_count", 32'(out_count), 32'h4);
        check("fullpp_no_ovf", 32'(out_overflow), 32'h0);
        check("fullpp_head", ext_out_data, 32'h2);
        @(negedge clock);
        check("fullpp_drain3", ext_out_data, 32'h3);
        @(negedge clock);
        check("fullpp_drain4", ext_out_data, 32'h4);
        @(negedge clock);
        check("fullpp_last", ext_out_data, 32'hB0);
        @(negedge clock);
        check("fullpp_empty", 32'(out_count), 32'h0);
        ext_out_ready = 1'b0;

        // Input handshake: accept, back-pressure, read-and-refill
        ext_in_valid = 1'b1;
        ext_in_data  = 32'hC0;
        @(negedge clock);
        check("in_data_c0", inport_data, 32'hC0);
        check("in_fresh_c0", 32'(inport_fresh), 32'h1);
        ext_in_data = 32'hC1;
        #1;
        check("in_ready_blocked", 32'(ext_in_ready), 32'h0);
        @(negedge clock);
        check("in_data_held", inport_data, 32'hC0);
        inport_rd = 1'b1;
        #1;
        check("in_ready_on_rd", 32'(ext_in_ready), 32'h1);
        @(negedge clock);
        check("in_data_c1", inport_data, 32'hC1);
        check("in_fresh_c1", 32'(inport_fresh), 32'h1);
        ext_in_valid = 1'b0;
        @(negedge clock);
        inport_rd = 1'b0;
        check("in_fresh_consumed", 32'(inport_fresh), 32'h0);
        check("in_no_underrun", 32'(in_underrun), 32'h0);

        // Underrun: read with nothing fresh; set wins over clear
        inport_rd = 1'b1;
        @(negedge clock);
        inport_rd = 1'b0;
        check("underrun_flag", 32'(in_underrun), 32'h1);
        check("underrun_data_stale", inport_data, 32'hC1);
        inport_rd = 1'b1;
        clr_flags = 1'b1;
        @(negedge clock);
        inport_rd = 1'b0;
        check("underrun_set_wins", 32'(in_underrun), 32'h1);
        @(negedge clock);
        clr_flags = 1'b0;
        check("underrun_cleared", 32'(in_underrun), 32'h0);

        // Asynchronous clear with queued words and a fresh input
        outport_wr   = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data  = 32'hD0;
        for (int i = 0; i < 3; i++) begin
            outport_data = 32'hE0 + 32'(i);
            @(negedge clock);
            ext_in_valid = 1'b0;
        end
        outport_wr = 1'b0;
        check("pre_clear_count", 32'(out_count), 32'h3);
        check("pre_clear_fresh", 32'(inport_fresh), 32'h1);
        check("pre_clear_head", ext_out_data, 32'hE0);
        #2;
        clear = 1'b1;
        #1;
        check_reset_values("async_clear");
        @(negedge clock);
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
